uart_program_loader: RTL and testbench

CPU-side boot loader; the device end of the host boot protocol. After reset it requests a program over UART and receives a 4-byte little-endian length. It then receives the program image and writes it word by word into instruction memory. It acknowledges with 0xAA, which tells the host to stream stdin, and then releases the core.

---
 rtl/uart_program_loader.sv | 165 ++++++++++++++++
 tb/tb_uart_program_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Boot loader: requests a program over UART, stores the image into instruction
// memory word by word, acknowledges, then signals that the core may run.
module uart_program_loader #(
    parameter int         IMEM_ADDR_WIDTH = 15,
    parameter logic [7:0] REQ_BYTE        = 8'h99,
    parameter logic [7:0] ACK_BYTE        = 8'hAA
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 rx_rdata,
    input  logic                       rx_rdata_ready,
    input  logic                       rx_ferr,
    output logic [7:0]                 tx_sdata,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic                       imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]                imem_wdata,
    output logic                       load_done,
    output logic                       load_error
);

    // Largest accepted image in bytes; 33 bits so the limit itself never wraps.
    localparam logic [32:0] SIZE_LIMIT = 33'd4 << IMEM_ADDR_WIDTH;

    typedef enum logic [2:0] {
        SEND_REQ,
        RECV_SIZE,
        RECV_PROG,
        SEND_ACK,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        guard;
    logic        tx_fire;
    logic [7:0]  tx_byte;
    logic        write_fire;
    logic [31:0] cnt;
    logic [31:0] size;
    logic [31:0] word;
    logic [31:0] size_new;
    logic [31:0] word_new;
    logic        rx_ok;
    logic        last_byte;
    logic        word_end;

    assign rx_ok     = rx_rdata_ready && !rx_ferr;
    assign size_new  = {rx_rdata, size[31:8]};
    assign last_byte = (cnt + 32'd1 == size);
    assign word_end  = (cnt[1:0] == 2'd3) || last_byte;

    // A new word starts from zero, so a trailing partial word is zero-padded.
    always_comb begin
        word_new = (cnt[1:0] == 2'd0) ? 32'd0 : word;
        word_new[{cnt[1:0], 3'b000} +: 8] = rx_rdata;
    end

    always_comb begin
        state_next = state;
        tx_fire    = 1'b0;
        tx_byte    = REQ_BYTE;
        write_fire = 1'b0;
        case (state)
            SEND_REQ: begin
                if (!tx_busy && !guard) begin
                    tx_fire    = 1'b1;
                    state_next = RECV_SIZE;
                end
            end
            RECV_SIZE: begin
                if (rx_rdata_ready) begin
                    if (rx_ferr) begin
                        state_next = ERROR;
                    end else if (cnt[1:0] == 2'd3) begin
                        if (size_new == 32'd0) begin
                            state_next = SEND_ACK;
                        end else if ({1'b0, size_new} > SIZE_LIMIT) begin
                            state_next = ERROR;
                        end else begin
                            state_next = RECV_PROG;
                        end
                    end
                end
            end
            RECV_PROG: begin
                if (rx_rdata_ready) begin
                    if (rx_ferr) begin
                        state_next = ERROR;
                    end else begin
                        write_fire = word_end;
                        if (last_byte) begin
                            state_next = SEND_ACK;
                        end
                    end
                end
            end
            SEND_ACK: begin
                tx_byte = ACK_BYTE;
                if (!tx_busy && !guard) begin
                    tx_fire    = 1'b1;
                    state_next = DONE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEND_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Registered outputs: the write lands the cycle after its completing byte,
    // while word assembly for the next byte proceeds independently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            guard      <= 1'b0;
            tx_start   <= 1'b0;
            tx_sdata   <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            cnt        <= 32'd0;
        end else begin
            guard    <= tx_fire;
            tx_start <= tx_fire;
            if (tx_fire) begin
                tx_sdata <= tx_byte;
            end
            imem_we <= write_fire;
            if (write_fire) begin
                imem_addr  <= cnt[IMEM_ADDR_WIDTH+1:2];
                imem_wdata <= word_new;
            end
            if (tx_fire && state == SEND_ACK) begin
                load_done <= 1'b1;
            end
            load_error <= (state_next == ERROR);
            if (state == RECV_SIZE && rx_ok) begin
                cnt <= (cnt[1:0] == 2'd3) ? 32'd0 : cnt + 32'd1;
            end else if (state == RECV_PROG && rx_ok) begin
                cnt <= cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == RECV_SIZE && rx_ok) begin
            size <= size_new;
        end
        if (state == RECV_PROG && rx_ok) begin
            word <= word_new;
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: randomized byte streams checked against a
// reference model of the boot protocol (expected words, tx bytes, final flags).
module tb_uart_program_loader;

    localparam int AW        = 4;
    localparam int MAX_BYTES = 4 * (2 ** AW);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_rdata = 8'd0;
    logic          rx_rdata_ready = 1'b0;
    logic          rx_ferr = 1'b0;
    logic [7:0]    tx_sdata;
    logic          tx_start;
    logic          tx_busy;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          load_done;
    logic          load_error;

    uart_program_loader #(
        .IMEM_ADDR_WIDTH(AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_rdata      (rx_rdata),
        .rx_rdata_ready(rx_rdata_ready),
        .rx_ferr       (rx_ferr),
        .tx_sdata      (tx_sdata),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .load_done     (load_done),
        .load_error    (load_error)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  tx_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          dbl = 0;
    logic        tx_prev = 1'b0;
    logic [7:0]  prog[$];

    // Observe DUT events on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) begin
                wa_q.push_back(32'(imem_addr));
                wd_q.push_back(imem_wdata);
            end
            if (tx_start) tx_q.push_back(tx_sdata);
            if (tx_start && tx_prev) dbl <= dbl + 1;
        end
        tx_prev <= tx_start;
    end

    // UART_TX stand-in: busy for a few cycles after every start strobe.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                tx_busy = 1'b1;
                repeat ($urandom_range(2, 6)) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic f, input int gap);
        rx_rdata       = b;
        rx_ferr        = f;
        rx_rdata_ready = 1'b1;
        @(posedge clk); #1;
        rx_rdata_ready = 1'b0;
        rx_ferr        = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset(input bit chk, output int tx0, output int wr0, output int d0);
        rx_rdata_ready = 1'b0;
        rx_ferr        = 1'b0;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (chk) begin
            check_val("rst/tx_start", 32'(tx_start), 32'd0);
            check_val("rst/tx_sdata", 32'(tx_sdata), 32'd0);
            check_val("rst/imem_we", 32'(imem_we), 32'd0);
            check_val("rst/imem_addr", 32'(imem_addr), 32'd0);
            check_val("rst/imem_wdata", imem_wdata, 32'd0);
            check_val("rst/load_done", 32'(load_done), 32'd0);
            check_val("rst/load_error", 32'(load_error), 32'd0);
        end
        tx0   = tx_q.size();
        wr0   = wd_q.size();
        d0    = dbl;
        reset = 1'b0;
    endtask

    task automatic wait_request(input string name, input int tx0);
        int waited = 0;
        while (tx_q.size() == tx0 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check_val({name, "/req_seen"}, 32'(tx_q.size() - tx0), 32'd1);
        check_val({name, "/req_byte"}, (tx_q.size() > tx0) ? 32'(tx_q[tx0]) : 32'd0, 32'h99);
        repeat (5) @(posedge clk);
        #1;
        check_val({name, "/no_second_tx"}, 32'(tx_q.size() - tx0), 32'd1);
    endtask

    task automatic fill_random();
        prog.delete();
        for (int i = 0; i < MAX_BYTES; i++) prog.push_back(8'($urandom));
    endtask

    // One complete boot attempt; ferr_idx indexes the combined size+image stream.
    task automatic run_case(input string name, input logic [31:0] n, input int ferr_idx, input bit chk_rst);
        int          tx0, wr0, d0, nsend, cut, nwords, waited;
        bit          exp_err;
        logic [31:0] exp_w;
        apply_reset(chk_rst, tx0, wr0, d0);
        wait_request(name, tx0);

        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], ferr_idx == i, $urandom_range(0, 2));
        nsend = (n <= 32'(MAX_BYTES)) ? int'(n) : 4;
        for (int i = 0; i < nsend; i++) send_byte(prog[i], ferr_idx == i + 4, $urandom_range(0, 2));

        waited = 0;
        while (!(load_done || load_error) && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        check_val({name, "/finished"}, 32'(load_done | load_error), 32'd1);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 1);
        repeat (10) @(posedge clk);
        #1;

        exp_err = 1'b0;
        cut     = nsend;
        if (ferr_idx >= 0 && ferr_idx < 4) begin
            exp_err = 1'b1;
            cut     = 0;
        end else if (n > 32'(MAX_BYTES)) begin
            exp_err = 1'b1;
            cut     = 0;
        end else if (ferr_idx >= 4 && ferr_idx - 4 < nsend) begin
            exp_err = 1'b1;
            cut     = ferr_idx - 4;
        end
        nwords = exp_err ? cut / 4 : (nsend + 3) / 4;

        check_val({name, "/wr_count"}, 32'(wd_q.size() - wr0), 32'(nwords));
        for (int w = 0; w < nwords; w++) begin
            exp_w = 32'd0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < nsend) exp_w[8*k +: 8] = prog[4*w+k];
            if (wr0 + w < wd_q.size()) begin
                check_val($sformatf("%s/wr%0d_addr", name, w), wa_q[wr0+w], 32'(w));
                check_val($sformatf("%s/wr%0d_data", name, w), wd_q[wr0+w], exp_w);
            end
        end
        check_val({name, "/tx_count"}, 32'(tx_q.size() - tx0), exp_err ? 32'd1 : 32'd2);
        if (!exp_err && tx_q.size() > tx0 + 1)
            check_val({name, "/ack_byte"}, 32'(tx_q[tx0+1]), 32'hAA);
        check_val({name, "/load_done"}, 32'(load_done), 32'(!exp_err));
        check_val({name, "/load_error"}, 32'(load_error), 32'(exp_err));
        check_val({name, "/tx_back_to_back"}, 32'(dbl - d0), 32'd0);
    endtask

    initial begin
        int tx0, wr0, d0;
        logic [7:0] fixed8[8];
        fixed8 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

        fill_random();
        for (int i = 0; i < 8; i++) prog[i] = fixed8[i];
        run_case("size8", 32'd8, -1, 1'b1);

        fill_random();
        for (int i = 0; i < 6; i++) prog[i] = 8'(i + 1);
        run_case("size6", 32'd6, -1, 1'b0);

        run_case("size0", 32'd0, -1, 1'b0);
        fill_random();
        run_case("size_0x44", 32'h44, -1, 1'b0);
        run_case("size_max", 32'(MAX_BYTES), -1, 1'b0);
        run_case("size_max_plus1", 32'(MAX_BYTES + 1), -1, 1'b0);
        run_case("size_huge", 32'h8000_0010, -1, 1'b0);
        run_case("ferr_prog3", 32'd8, 6, 1'b0);
        run_case("ferr_size2", 32'd8, 1, 1'b0);

        // Abort a load mid-image with an off-edge reset, then reload from scratch.
        fill_random();
        prog[4] = 8'h5A;
        apply_reset(1'b0, tx0, wr0, d0);
        wait_request("abort", tx0);
        for (int i = 0; i < 4; i++) send_byte(8'(i == 0 ? 40 : 0), 1'b0, 0);
        for (int i = 0; i < 9; i++) send_byte(prog[i], 1'b0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_val("abort/imem_we", 32'(imem_we), 32'd0);
        check_val("abort/imem_addr", 32'(imem_addr), 32'd0);
        check_val("abort/imem_wdata", imem_wdata, 32'd0);
        check_val("abort/tx_start", 32'(tx_start), 32'd0);
        check_val("abort/load_done", 32'(load_done), 32'd0);
        run_case("reload", 32'd40, -1, 1'b1);

        for (int t = 0; t < 10; t++) begin
            fill_random();
            run_case($sformatf("rand%0d", t), 32'($urandom_range(1, MAX_BYTES)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAX_BYTES + 3)) : -1,
                     1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
